// File: rtl/rom_load_pkg.sv
// Shared types and helpers for the HPS ROM download controller.
package rom_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_SETTLE,
        ST_RUN
    } state_t;

    localparam int unsigned REGION_COUNT = 2;

    // One-hot region select; all-zero means "no region", so nothing is written.
    typedef logic [REGION_COUNT-1:0] region_t;

    localparam region_t REGION_NONE = '0;
    localparam region_t REGION_0    = 2'b01;
    localparam region_t REGION_1    = 2'b10;

    typedef struct packed {
        region_t     region;
        logic [15:0] local_addr;
    } decode_t;

    // Maps a full 25-bit download address onto a region and region-local
    // address. The compare uses every address bit so aliases above 64K are
    // rejected rather than folded back into a region.
    function automatic decode_t region_decode(
        input logic [24:0] addr,
        input logic [15:0] r0_bytes,
        input logic [15:0] r1_bytes
    );
        decode_t     d;
        logic [24:0] r0_end;
        logic [24:0] r1_end;
        r0_end       = {9'd0, r0_bytes};
        r1_end       = r0_end + {9'd0, r1_bytes};
        d.region     = REGION_NONE;
        d.local_addr = addr[15:0];
        if (addr < r0_end) begin
            d.region = REGION_0;
        end else begin
            d.local_addr = addr[15:0] - r0_bytes;
            if (addr < r1_end) begin
                d.region = REGION_1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/rom_load_ctrl_pulse_stretch.sv
// Counter-based pulse stretcher: a one-cycle start yields a registered pulse
// exactly STRETCH cycles long. Also usable for coin-pulse stretching.
module pulse_stretch #(
    parameter int unsigned STRETCH = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_start,
    output logic o_active,
    output logic o_last
);

    localparam logic [3:0] LP_LOAD = 4'(STRETCH - 1);

    logic [3:0] r_cnt;
    logic       r_active;

    // Load the counter on start, count down while active, drop after zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= LP_LOAD;
        end else if (r_active) begin
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign o_active = r_active;
    assign o_last   = r_active && (r_cnt == '0);

endmodule

// File: rtl/rom_load_ctrl.sv
// Sequences the HPS ioctl ROM download into the core ROM write port,
// validates the byte stream and owns the core reset.
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter logic [15:0] REGION0_BYTES = 16'h3800,
    parameter logic [15:0] REGION1_BYTES = 16'h1000,
    parameter int unsigned WR_STRETCH    = 4,
    parameter int unsigned SETTLE_CYCLES = 64
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        rst_req,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [1:0]  region_sel,
    output logic        core_reset,
    output logic        load_ok,
    output logic        load_err
);

    localparam logic [16:0] LP_TOTAL       = {1'b0, REGION0_BYTES} + {1'b0, REGION1_BYTES};
    localparam logic [7:0]  LP_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [16:0] r_cnt;
    logic        r_err;
    logic        r_load_ok;
    logic        r_load_err;
    logic [15:0] r_dn_addr;
    logic [7:0]  r_dn_data;
    region_t     r_region_sel;
    logic        r_core_reset;
    logic        r_dl_prev;
    logic [7:0]  r_settle;

    logic        w_dl_rise;
    logic        w_enter_load;
    logic        w_accept;
    logic        w_settle_done;
    logic        w_good;
    logic        w_mismatch;
    logic        w_proto_err;
    logic        w_stretch_active;
    logic        w_stretch_last;
    decode_t     w_dec;

    assign w_dl_rise     = ioctl_download && !r_dl_prev;
    assign w_mismatch    = (ioctl_addr != {8'd0, r_cnt});
    assign w_dec         = region_decode(ioctl_addr, REGION0_BYTES, REGION1_BYTES);
    assign w_settle_done = (r_state == ST_SETTLE) && (r_settle == LP_SETTLE_LAST);
    assign w_good        = !r_err && (r_cnt == LP_TOTAL);
    assign w_proto_err   = (r_state == ST_WRITE) && ioctl_wr;

    pulse_stretch #(
        .STRETCH(WR_STRETCH)
    ) u_wr_stretch (
        .i_clk    (clk_sys),
        .i_reset  (reset),
        .i_start  (w_accept),
        .o_active (w_stretch_active),
        .o_last   (w_stretch_last)
    );

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and strobe acceptance.
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_enter_load = 1'b0;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (w_dl_rise) begin
                    w_next       = ST_LOAD;
                    w_enter_load = 1'b1;
                end
            end
            ST_LOAD: begin
                if (ioctl_wr) begin
                    w_accept = 1'b1;
                    w_next   = ST_WRITE;
                end else if (!ioctl_download) begin
                    w_next = ST_SETTLE;
                end
            end
            ST_WRITE: begin
                if (w_stretch_last) begin
                    w_next = ioctl_download ? ST_LOAD : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_settle_done) begin
                    w_next = w_good ? ST_RUN : ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath: latched write outputs, byte counter, error and result flags, core reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_load_ok    <= 1'b0;
            r_load_err   <= 1'b0;
            r_dn_addr    <= '0;
            r_dn_data    <= '0;
            r_region_sel <= REGION_NONE;
            r_core_reset <= 1'b1;
            r_dl_prev    <= 1'b0;
            r_settle     <= '0;
        end else begin
            r_dl_prev <= ioctl_download;
            r_settle  <= (r_state == ST_SETTLE) ? r_settle + 8'd1 : 8'd0;
            if (w_enter_load) begin
                r_cnt      <= '0;
                r_err      <= 1'b0;
                r_load_ok  <= 1'b0;
                r_load_err <= 1'b0;
            end
            if (w_accept) begin
                r_dn_addr    <= w_dec.local_addr;
                r_dn_data    <= ioctl_dout;
                r_region_sel <= w_mismatch ? REGION_NONE : w_dec.region;
                if (r_cnt != 17'h1FFFF) begin
                    r_cnt <= r_cnt + 17'd1;
                end
                if (w_mismatch || (w_dec.region == REGION_NONE)) begin
                    r_err <= 1'b1;
                end
            end
            if (w_proto_err) begin
                r_err <= 1'b1;
            end
            if (w_settle_done) begin
                if (w_good) begin
                    r_load_ok <= 1'b1;
                end else begin
                    r_load_err <= 1'b1;
                end
            end
            // Keyed off the next state so the first RUN cycle already follows rst_req.
            r_core_reset <= (w_next == ST_RUN) ? rst_req : 1'b1;
        end
    end

    assign ioctl_wait = w_stretch_active;
    assign dn_wr      = w_stretch_active;
    assign dn_addr    = r_dn_addr;
    assign dn_data    = r_dn_data;
    assign region_sel = r_region_sel;
    assign core_reset = r_core_reset;
    assign load_ok    = r_load_ok;
    assign load_err   = r_load_err;

endmodule

// File: doc/rom_load_ctrl.md
# rom_load_ctrl

Sequences the HPS ROM download (ioctl stream) into the arcade core's ROM write port and owns the core reset. It decodes each byte into a ROM region and stretches each write so a 10 MHz-clocked ROM captures it. It back-pressures the HPS with `ioctl_wait`, validates the stream, and releases the core from reset only after a complete, error-free load plus a settle interval. It sits between `hps_io` and the core top, replacing direct `dn_*`/reset wiring.

## Interface
- `REGION0_BYTES`, 16'h3800: size of region 0 (CPU program ROM), starting at byte 0.
- `REGION1_BYTES`, 16'h1000: size of region 1 (speech ROM), immediately after region 0.
- `WR_STRETCH`, 4: `clk_sys` cycles each `dn_wr` is held high. Range 1..15.
- `SETTLE_CYCLES`, 64: reset-hold cycles after download end. Range 1..255.

Ports (clock and reset first):
- `clk_sys` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high.
- `rst_req` in 1: user/menu reset request, honoured only in RUN.
- `ioctl_download` in 1: download window.
- `ioctl_wr` in 1: byte strobe, one cycle.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_wait` out 1: HPS must hold the next strobe while high.
- `dn_addr` out 16: region-local byte address.
- `dn_data` out 8: write data.
- `dn_wr` out 1: stretched write strobe.
- `region_sel` out 2: one-hot; bit0 selects region 0, bit1 selects region 1.
- `core_reset` out 1: reset to the core.
- `load_ok` out 1: last load completed correctly (sticky).
- `load_err` out 1: last load failed (sticky).

## Operation
- States: IDLE, LOAD, WRITE, SETTLE, RUN.
- IDLE: `core_reset=1`. Rising `ioctl_download` goes to LOAD, which clears `load_ok`/`load_err` and the 17-bit byte counter `cnt`.
- LOAD: on `ioctl_wr`, latch the outputs and go to WRITE.
  - `dn_addr` is `ioctl_addr[15:0]` if below REGION0_BYTES, otherwise minus REGION0_BYTES.
  - `region_sel` is the decoded region.
  - `dn_data` is `ioctl_dout`.
  - `dn_wr=1`, `ioctl_wait=1`, `cnt+1`.
- Error conditions in LOAD, each setting internal `err`:
  - `ioctl_addr != cnt` (out-of-order byte).
  - `ioctl_addr >= REGION0_BYTES+REGION1_BYTES`.
  - In both cases `region_sel=0`, so no write reaches the core, but `dn_wr` timing is unchanged.
- WRITE: count WR_STRETCH cycles, then clear `dn_wr`/`ioctl_wait`. Return to LOAD, or go to SETTLE if `ioctl_download` is already low.
  - A strobe arriving during WRITE is a protocol violation: it sets `err` and the byte is dropped.
- LOAD with `ioctl_download` falling: go to SETTLE.
- SETTLE: `core_reset=1` for SETTLE_CYCLES. Then:
  - if `!err && cnt==REGION0_BYTES+REGION1_BYTES`: go to RUN with `load_ok=1`;
  - otherwise: go to IDLE with `load_err=1`.
- RUN: `core_reset = rst_req` (registered). Rising `ioctl_download` goes to LOAD.
- Width rules:
  - `cnt` saturates at 17'h1FFFF; no wrap.
  - Region decode compares the full 25-bit address, so high address bits are never ignored.

## Timing
- All outputs are registered.
- Reset values: IDLE, `core_reset=1`, `ioctl_wait=0`, `dn_wr=0`, `dn_addr=0`, `dn_data=0`, `region_sel=0`, `load_ok=0`, `load_err=0`.
- Strobe sampled at edge t:
  - `dn_*`, `region_sel` and `ioctl_wait` are valid from t+1;
  - `dn_wr` is high for cycles t+1..t+WR_STRETCH;
  - `dn_addr`/`dn_data`/`region_sel` stay stable until the next accepted strobe.
- Peak throughput: one byte per WR_STRETCH+1 cycles.
- `ioctl_download` falls during WRITE: the current write completes in full before SETTLE.
- `ioctl_download` and `ioctl_wr` in the same cycle from IDLE/RUN: enter LOAD, and the strobe is accepted one cycle later only if still present. Otherwise it is lost and counted as an address mismatch on the next byte.
- `reset` mid-operation: immediate return to IDLE next edge. Any active `dn_wr` drops, and the sticky flags clear.
- `rst_req` in non-RUN states: ignored (`core_reset` is already 1).
- The first cycle of RUN has `core_reset = rst_req`, never a glitch low while `rst_req` is high.

## Structure
- Package `rom_load_pkg`:
  - state enum;
  - `REGION_COUNT=2`;
  - `region_t` one-hot type;
  - a function `region_decode(addr, r0_bytes, r1_bytes)` returning region and local address.
- Sub-module `pulse_stretch` (counter-based, WR_STRETCH width): generates `dn_wr`/`ioctl_wait` from a one-cycle start. It is reusable for coin-pulse stretching.

## Test plan
- Full load, 0x4800 sequential bytes, `ioctl_download` drops → each `dn_wr` high exactly 4 cycles.
  - Address 0x37FF gives region_sel=01, dn_addr=0x37FF.
  - Address 0x3800 gives region_sel=10, dn_addr=0x0000.
  - After 64 settle cycles: `core_reset=0`, `load_ok=1`.
- Short load of 0x4000 bytes → after SETTLE: IDLE, `load_err=1`, `core_reset` stays 1.
- Byte at address 5 sent when `cnt=4` → that write has region_sel=00 and `load_err=1` at end.
- Second strobe 2 cycles after the first (during WRITE) → dropped, `ioctl_wait` high throughout, `load_err=1`.
- RUN with `rst_req` pulsed 3 cycles → `core_reset` high for exactly 3 cycles, delayed by 1.
- `reset` asserted during WRITE at stretch cycle 2 → next edge: `dn_wr=0`, `ioctl_wait=0`, `core_reset=1`, flags clear.
